// File: rtl/conv1_pkg.sv
// conv1_pkg: shared constants and types for the first convolution layer.
//   - pixel_t   : unsigned 8-bit input pixel
//   - coef_t    : signed 8-bit weight / bias
//   - result_t  : signed 15-bit filter output
//   - acc_t     : signed accumulator
//   - WEIGHTS   : [filter][row][col], row 0 is the oldest row of the window
//   - BIAS      : per-filter bias, added as (bias <<< SHIFT) to the accumulator
//   - fit_result: reduces a shifted accumulator to result_t. With CONV1_SAT_EN
//                 defined it saturates; otherwise it keeps the low 15 bits.
package conv1_pkg;

    localparam int NF    = 3;
    localparam int KS    = 5;
    localparam int RES_W = 15;
    // 25 taps of 255 x |128| plus a shifted bias stay well below 2^23.
    localparam int ACC_W = 24;

    typedef logic        [7:0]       pixel_t;
    typedef logic signed [7:0]       coef_t;
    typedef logic signed [RES_W-1:0] result_t;
    typedef logic signed [ACC_W-1:0] acc_t;

    // Filter 0: flat box. Filter 1: -(5*i+j+1). Filter 2: +(5*i+j+1).
    localparam coef_t WEIGHTS [NF][KS][KS] = '{
        '{ '{8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1},
           '{8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1},
           '{8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1},
           '{8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1},
           '{8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1} },
        '{ '{-8'sd1,  -8'sd2,  -8'sd3,  -8'sd4,  -8'sd5},
           '{-8'sd6,  -8'sd7,  -8'sd8,  -8'sd9,  -8'sd10},
           '{-8'sd11, -8'sd12, -8'sd13, -8'sd14, -8'sd15},
           '{-8'sd16, -8'sd17, -8'sd18, -8'sd19, -8'sd20},
           '{-8'sd21, -8'sd22, -8'sd23, -8'sd24, -8'sd25} },
        '{ '{8'sd1,  8'sd2,  8'sd3,  8'sd4,  8'sd5},
           '{8'sd6,  8'sd7,  8'sd8,  8'sd9,  8'sd10},
           '{8'sd11, 8'sd12, 8'sd13, 8'sd14, 8'sd15},
           '{8'sd16, 8'sd17, 8'sd18, 8'sd19, 8'sd20},
           '{8'sd21, 8'sd22, 8'sd23, 8'sd24, 8'sd25} }
    };

    localparam coef_t BIAS [NF] = '{8'sd3, -8'sd5, 8'sd7};

    function automatic result_t fit_result(input acc_t v);
        result_t r;
`ifdef CONV1_SAT_EN
        if (v > 24'sd16383) begin
            r = result_t'(15'h3FFF);
        end else if (v < -24'sd16384) begin
            r = result_t'(15'h4000);
        end else begin
            r = v[RES_W-1:0];
        end
`else
        r = v[RES_W-1:0];
`endif
        return r;
    endfunction

endpackage

// File: rtl/conv1_buf.sv
// conv1_buf: line buffer and KxK window generator.
// A single shift register holds the last (K-1)*WIDTH + K-1 accepted pixels.
// The window is formed combinationally so its bottom-right tap is the pixel
// being presented this cycle (pix_i); tap (i,j) is that pixel delayed by
// (K-1-i)*WIDTH + (K-1-j) accepted samples.
// Ports:
//   clk        in   clock
//   shift_en_i in   1 = pix_i is an accepted pixel, shift it in
//   pix_i      in   current pixel
//   win_o      out  window [row][col], row 0 oldest
// Contents are intentionally unreset: a valid window only ever spans pixels
// of the current frame.
module conv1_buf
    import conv1_pkg::*;
#(
    parameter int WIDTH = 28,
    parameter int K     = 5
) (
    input  logic   clk,
    input  logic   shift_en_i,
    input  pixel_t pix_i,
    output pixel_t win_o [K][K]
);

    localparam int DEPTH = (K - 1) * WIDTH + K - 1;

    pixel_t sr_q [DEPTH];

    // pixel delay line, advanced once per accepted pixel
    always_ff @(posedge clk) begin
        if (shift_en_i) begin
            sr_q[0] <= pix_i;
            for (int d = 1; d < DEPTH; d++) begin
                sr_q[d] <= sr_q[d-1];
            end
        end
    end

    for (genvar gi = 0; gi < K; gi++) begin : g_row
        for (genvar gj = 0; gj < K; gj++) begin : g_col
            localparam int D = (K - 1 - gi) * WIDTH + (K - 1 - gj);
            if (D == 0) begin : g_cur
                assign win_o[gi][gj] = pix_i;
            end else begin : g_del
                assign win_o[gi][gj] = sr_q[D-1];
            end
        end
    end

endmodule

// File: rtl/conv1_layer.sv
// conv1_layer: streaming 3-filter KxK convolution over a WIDTH x HEIGHT image.
// One pixel per clock in raster order; the first sample after reset release
// is dropped. Each filter result is registered the clock after the pixel
// that completes its window, and held while valid_out_conv is low.
// Ports:
//   clk                  in   rising-edge clock
//   rst_n                in   synchronous active-low reset
//   data_in              in   unsigned 8-bit pixel
//   conv_out_1..3        out  signed 15-bit filter results
//   valid_out_conv       out  high while conv_out_* hold a fresh window result
// Configuration macro: CONV1_SAT_EN (saturate instead of wrap to 15 bits).
module conv1_layer
    import conv1_pkg::*;
#(
    parameter int WIDTH  = 28,
    parameter int HEIGHT = 28,
    parameter int K      = 5,
    parameter int SHIFT  = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  pixel_t                  data_in,
    output logic signed [RES_W-1:0] conv_out_1,
    output logic signed [RES_W-1:0] conv_out_2,
    output logic signed [RES_W-1:0] conv_out_3,
    output logic                    valid_out_conv
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam logic [CW-1:0] COL_LAST  = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(HEIGHT - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          first_q, first_d;   // next sample is the one to discard
    logic          valid_q, valid_d;
    result_t       res_q [NF];
    result_t       res_d [NF];

    logic          shift_en_s;
    pixel_t        win_s [K][K];
    acc_t          acc_s [NF];
    result_t       fit_s [NF];

    assign shift_en_s = rst_n & ~first_q;

    conv1_buf #(
        .WIDTH (WIDTH),
        .K     (K)
    ) u_buf (
        .clk        (clk),
        .shift_en_i (shift_en_s),
        .pix_i      (data_in),
        .win_o      (win_s)
    );

    // multiply-accumulate of the current window for every filter
    always_comb begin
        for (int f = 0; f < NF; f++) begin
            acc_s[f] = acc_t'(BIAS[f]) <<< SHIFT;
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    acc_s[f] = acc_s[f]
                             + acc_t'($signed({1'b0, win_s[i][j]}))
                             * acc_t'(WEIGHTS[f][i][j]);
                end
            end
            fit_s[f] = fit_result(acc_s[f] >>> SHIFT);
        end
    end

    // raster position tracking, valid decode and output capture
    always_comb begin
        first_d = 1'b0;
        col_d   = col_q;
        row_d   = row_q;
        valid_d = 1'b0;
        res_d   = res_q;
        if (first_q) begin
            col_d = col_q;
        end else begin
            valid_d = (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);
            if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
            if (valid_d) begin
                res_d = fit_s;
            end else begin
                res_d = res_q;
            end
        end
    end

    // state and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            first_q <= 1'b1;
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            for (int f = 0; f < NF; f++) begin
                res_q[f] <= '0;
            end
        end else begin
            first_q <= first_d;
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            res_q   <= res_d;
        end
    end

    assign conv_out_1     = res_q[0];
    assign conv_out_2     = res_q[1];
    assign conv_out_3     = res_q[2];
    assign valid_out_conv = valid_q;

endmodule

// File: tb/tb_conv1_layer.sv
// tb_conv1_layer: directed self-checking bench for conv1_layer.
// Expected values are hand-derived from the filter definitions:
//   bias = {3, -5, 7}; filter 0 all ones, filter 1 = -(5i+j+1),
//   filter 2 = +(5i+j+1). All-255 frame -> {102, -1300, 1301}.
module tb_conv1_layer;

    logic               clk = 1'b0;
    logic               rst_n;
    logic        [7:0]  data_in;
    logic signed [14:0] conv_out_1;
    logic signed [14:0] conv_out_2;
    logic signed [14:0] conv_out_3;
    logic               valid_out_conv;

    int n_vec  = 0;
    int n_miss = 0;
    int edge_cnt;
    int first_valid_edge;
    int valid_cnt;
    int last_exp [3];

    conv1_layer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_in        (data_in),
        .conv_out_1     (conv_out_1),
        .conv_out_2     (conv_out_2),
        .conv_out_3     (conv_out_3),
        .valid_out_conv (valid_out_conv)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, act, exp, edge_cnt);
        end
    endtask

    function automatic logic [7:0] pixel_at(input int mode, input int r, input int c);
        case (mode)
            1:       return (r == 0 && c == 0) ? 8'd64 : 8'd0;
            2:       return 8'd255;
            3:       return (r == 2 && c == 3) ? 8'd64 : 8'd0;
            default: return 8'd0;
        endcase
    endfunction

    // expected result of filter f for the window whose top-left is (r,c)
    function automatic int exp_out(input int mode, input int f, input int r, input int c);
        int b;
        int w;
        b = (f == 0) ? 3 : (f == 1) ? -5 : 7;
        case (mode)
            1: begin
                if (r == 0 && c == 0) return b + ((f == 1) ? -1 : 1);
                else return b;
            end
            2: return (f == 0) ? 102 : (f == 1) ? -1300 : 1301;
            3: begin
                if (r <= 2 && c <= 3) begin
                    w = (f == 0) ? 1 : 5 * (2 - r) + (3 - c) + 1;
                    if (f == 1) w = -w;
                    return b + w;
                end else begin
                    return b;
                end
            end
            default: return b;
        endcase
    endfunction

    task automatic step(input logic [7:0] p);
        data_in = p;
        @(posedge clk);
        #1;
        if (rst_n) edge_cnt++;
    endtask

    task automatic check_outs(input string tag);
        chk({tag, "_o1"}, conv_out_1, last_exp[0]);
        chk({tag, "_o2"}, conv_out_2, last_exp[1]);
        chk({tag, "_o3"}, conv_out_3, last_exp[2]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(8'hC3);
        for (int f = 0; f < 3; f++) last_exp[f] = 0;
        chk("rst_valid", valid_out_conv, 0);
        check_outs("rst");
        step(8'h3C);
        rst_n    = 1'b1;
        edge_cnt = 0;
        step(8'h5A);   // discarded sample
        chk("discard_valid", valid_out_conv, 0);
        check_outs("discard");
    endtask

    task automatic pix(input int mode, input int n);
        int r;
        int c;
        logic exp_v;
        r = n / 28;
        c = n % 28;
        step(pixel_at(mode, r, c));
        exp_v = (r >= 4 && c >= 4);
        chk("valid", valid_out_conv, exp_v);
        if (exp_v) begin
            for (int f = 0; f < 3; f++) last_exp[f] = exp_out(mode, f, r - 4, c - 4);
        end
        check_outs("pix");
        if (valid_out_conv === 1'b1) begin
            valid_cnt++;
            if (first_valid_edge < 0) first_valid_edge = edge_cnt;
        end
    endtask

    task automatic run_frame(input int mode);
        int start_edge;
        start_edge       = edge_cnt;
        valid_cnt        = 0;
        first_valid_edge = -1;
        for (int n = 0; n < 784; n++) pix(mode, n);
        chk("valid_count", valid_cnt, 576);
        chk("first_valid_offset", first_valid_edge - start_edge, 117);
    endtask

    initial begin
        rst_n   = 1'b0;
        data_in = 8'h00;
        edge_cnt = 0;

        // all-zero frame: every result equals the bias
        do_reset();
        run_frame(0);
        chk("first_valid_edge", first_valid_edge, 118);

        // impulse at (0,0)
        do_reset();
        run_frame(1);
        chk("first_valid_edge_2", first_valid_edge, 118);

        // all-255 frame, then an impulse frame back to back without reset
        do_reset();
        run_frame(2);
        run_frame(3);

        // reset in the middle of a frame, then a clean impulse frame
        do_reset();
        for (int n = 0; n < 300; n++) pix(2, n);
        do_reset();
        run_frame(1);
        chk("first_valid_edge_3", first_valid_edge, 118);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
